// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   Decode-to-execute stage in front of the 16-entry register file.
//   Drives the register-file read selects from Rn/Rm, forwards same-cycle
//   write-back data into the operands, stalls on RAW/WAW hazards using a
//   per-register write scoreboard, and registers the operands for the ALU.
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   IN_*                  decoded instruction (valid/ready handshake)
//   RA_SEL/RB_SEL, RF_A/B register-file read selects and returned data
//   WB_VALID/RD/DATA      write-back port (clears scoreboard, forwards)
//   OUT_*                 registered operands to execute (valid/ready)
//   PENDING               scoreboard, bit i = write to Ri outstanding
module operand_fetch_stage #(
   parameter int DW   = 32,
   parameter int AW   = 4,
   parameter int NREG = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            IN_VALID,
   output logic            IN_READY,
   input  logic [AW-1:0]   IN_RN,
   input  logic [AW-1:0]   IN_RM,
   input  logic            IN_USE_RN,
   input  logic            IN_USE_RM,
   input  logic [AW-1:0]   IN_RD,
   input  logic            IN_WE,
   output logic [AW-1:0]   RA_SEL,
   output logic [AW-1:0]   RB_SEL,
   input  logic [DW-1:0]   RF_A,
   input  logic [DW-1:0]   RF_B,
   input  logic            WB_VALID,
   input  logic [AW-1:0]   WB_RD,
   input  logic [DW-1:0]   WB_DATA,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [DW-1:0]   OUT_A,
   output logic [DW-1:0]   OUT_B,
   output logic [AW-1:0]   OUT_RD,
   output logic            OUT_WE,
   output logic [NREG-1:0] PENDING
);

   logic [NREG-1:0] pending_q, pending_d;
   logic            out_valid_q, out_valid_d;
   logic [DW-1:0]   out_a_q, out_a_d;
   logic [DW-1:0]   out_b_q, out_b_d;
   logic [AW-1:0]   out_rd_q, out_rd_d;
   logic            out_we_q, out_we_d;

   logic            fwd_n, fwd_m, fwd_d;
   logic            raw_n, raw_m, waw, hazard, space, accept;
   logic [DW-1:0]   op_a, op_b;

   assign RA_SEL = IN_RN;
   assign RB_SEL = IN_RM;

   always_comb begin
      fwd_n  = WB_VALID && (WB_RD == IN_RN);
      fwd_m  = WB_VALID && (WB_RD == IN_RM);
      fwd_d  = WB_VALID && (WB_RD == IN_RD);
      op_a   = fwd_n ? WB_DATA : RF_A;
      op_b   = fwd_m ? WB_DATA : RF_B;
      // A write-back landing this cycle resolves the hazard on that register.
      raw_n  = IN_USE_RN && pending_q[IN_RN] && !fwd_n;
      raw_m  = IN_USE_RM && pending_q[IN_RM] && !fwd_m;
      waw    = IN_WE && pending_q[IN_RD] && !fwd_d;
      hazard = raw_n || raw_m || waw;
      space  = !out_valid_q || OUT_READY;
      accept = IN_VALID && space && !hazard;
   end

   assign IN_READY = space && !hazard;

   always_comb begin
      out_valid_d = out_valid_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_rd_d    = out_rd_q;
      out_we_d    = out_we_q;
      pending_d   = pending_q;

      if (accept) begin
         out_valid_d = 1'b1;
         out_a_d     = op_a;
         out_b_d     = op_b;
         out_rd_d    = IN_RD;
         out_we_d    = IN_WE;
      end else if (OUT_READY) begin
         out_valid_d = 1'b0;
      end

      // Clear first, then set: a new writer to the same index keeps it pending.
      if (WB_VALID)
         pending_d[WB_RD] = 1'b0;
      if (accept && IN_WE)
         pending_d[IN_RD] = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_rd_q    <= '0;
         out_we_q    <= 1'b0;
         pending_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         out_rd_q    <= out_rd_d;
         out_we_q    <= out_we_d;
         pending_q   <= pending_d;
      end
   end

   assign OUT_VALID = out_valid_q;
   assign OUT_A     = out_a_q;
   assign OUT_B     = out_b_q;
   assign OUT_RD    = out_rd_q;
   assign OUT_WE    = out_we_q;
   assign PENDING   = pending_q;

endmodule
